// File: rtl/hrv_beat_gen.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// hrv_beat_gen
//
// Synthetic heartbeat generator. Emits R-peak pulses whose RR intervals
// follow a programmable nominal period with a 4-phase respiratory sinus
// arrhythmia modulation (+delta, 0, -delta, 0). Bursts are either finite
// (n_beats beats) or continuous (n_beats = 0), with start/abort control and
// a one-cycle done strobe at normal completion.
//
// Parameters
//   TICK_DIV  clk cycles per interval tick (>= 2)
//   PULSE_W   beat pulse width in clk cycles (1 <= PULSE_W < TICK_DIV)
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   ena       design enable; low freezes the FSM and all counters
//   start     single-cycle burst request, honoured only when idle
//   abort     stops a burst immediately, independent of ena
//   base_rr   nominal RR interval in ticks (latched at start)
//   delta     modulation amplitude in ticks (latched at start)
//   n_beats   beats per burst, 0 = continuous (latched at start)
//   beat      beat pulse, PULSE_W cycles high per beat
//   beat_cnt  beats emitted in the current or last burst
//   busy      burst in progress
//   done      one-cycle strobe at normal burst completion
// ---------------------------------------------------------------------------
module hrv_beat_gen #(
    parameter int TICK_DIV = 10000,
    parameter int PULSE_W  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] base_rr,
    input  logic [3:0] delta,
    input  logic [7:0] n_beats,
    output logic       beat,
    output logic [7:0] beat_cnt,
    output logic       busy,
    output logic       done
);

    // Counter widths derived from the parameters; both are at least 1 bit.
    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PC_W = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PULSE_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_WAIT,
        S_FIN
    } state_t;

    state_t           state;

    // Burst configuration captured when a start is accepted.
    logic [7:0]       cfg_base_rr;
    logic [3:0]       cfg_delta;
    logic [7:0]       cfg_n_beats;

    // Modulation phase, prescaler, tick counter and pulse-width counter.
    logic [1:0]       phase;
    logic [PS_W-1:0]  presc;
    logic [7:0]       tick_cnt;
    logic [PC_W-1:0]  pulse_cnt;

    logic signed [9:0] rr_off;
    logic signed [9:0] rr_sum;
    logic [7:0]       cur_interval;
    logic             interval_done;
    logic             pulse_done;
    logic             last_beat;

    // Current interval length in ticks: base_rr plus the phase offset,
    // computed signed so that a negative or zero result can be clamped to 1
    // and an overflow above 255 clamped to 255.
    always_comb begin
        rr_off = 10'sd0;
        case (phase)
            2'd0:    rr_off = $signed({6'b000000, cfg_delta});
            2'd2:    rr_off = -$signed({6'b000000, cfg_delta});
            default: rr_off = 10'sd0;
        endcase
        rr_sum = $signed({2'b00, cfg_base_rr}) + rr_off;
        if (rr_sum < 10'sd1) begin
            cur_interval = 8'd1;
        end else if (rr_sum > 10'sd255) begin
            cur_interval = 8'd255;
        end else begin
            cur_interval = rr_sum[7:0];
        end
    end

    // The prescaler and tick counter both restart on every beat rising edge,
    // so the interval ends on the last prescaler cycle of its last tick. The
    // PULSE and WAIT cycles together therefore span exactly
    // cur_interval * TICK_DIV cycles between rising edges.
    assign interval_done = (presc == PS_LAST) && (tick_cnt == (cur_interval - 8'd1));
    assign pulse_done    = (pulse_cnt == PC_LAST);
    assign last_beat     = (cfg_n_beats != 8'd0) && (beat_cnt == cfg_n_beats);

    // Main FSM. Abort outranks everything, including a low ena, so a burst
    // can always be stopped. With ena low nothing else moves, so outputs and
    // counters simply hold. Every output is a register updated together with
    // the state it belongs to, so beat/busy/done change on the same edge as
    // the state transition that implies them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            beat        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            beat_cnt    <= 8'd0;
            cfg_base_rr <= 8'd0;
            cfg_delta   <= 4'd0;
            cfg_n_beats <= 8'd0;
            phase       <= 2'd0;
            presc       <= '0;
            tick_cnt    <= 8'd0;
            pulse_cnt   <= '0;
        end else if (abort) begin
            state     <= S_IDLE;
            beat      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            presc     <= '0;
            tick_cnt  <= 8'd0;
            pulse_cnt <= '0;
        end else if (ena) begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Accepting a start enters PULSE directly, so the first
                    // beat counts as beat 1 on the very next cycle.
                    if (start) begin
                        cfg_base_rr <= base_rr;
                        cfg_delta   <= delta;
                        cfg_n_beats <= n_beats;
                        beat_cnt    <= 8'd1;
                        phase       <= 2'd0;
                        presc       <= '0;
                        tick_cnt    <= 8'd0;
                        pulse_cnt   <= '0;
                        beat        <= 1'b1;
                        busy        <= 1'b1;
                        state       <= S_PULSE;
                    end
                end

                S_PULSE: begin
                    // The prescaler keeps running through the pulse because
                    // the interval is measured from the rising edge.
                    if (presc == PS_LAST) begin
                        presc    <= '0;
                        tick_cnt <= tick_cnt + 8'd1;
                    end else begin
                        presc <= presc + 1'b1;
                    end
                    if (pulse_done) begin
                        pulse_cnt <= '0;
                        beat      <= 1'b0;
                        if (last_beat) begin
                            // A finite burst ends straight after its last
                            // pulse; no trailing interval is generated.
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            state <= S_WAIT;
                        end
                    end else begin
                        pulse_cnt <= pulse_cnt + 1'b1;
                    end
                end

                S_WAIT: begin
                    if (interval_done) begin
                        presc    <= '0;
                        tick_cnt <= 8'd0;
                        phase    <= phase + 2'd1;
                        beat_cnt <= beat_cnt + 8'd1;
                        beat     <= 1'b1;
                        state    <= S_PULSE;
                    end else if (presc == PS_LAST) begin
                        presc    <= '0;
                        tick_cnt <= tick_cnt + 8'd1;
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end

                S_FIN: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                    beat  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hrv_beat_gen.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_hrv_beat_gen
//
// Self-checking bench for hrv_beat_gen with TICK_DIV=4, PULSE_W=2.
// Finite bursts come from a table of {config, expected edge cycles, expected
// done cycle}; the expected edges are pushed to a scoreboard queue when the
// burst is launched and popped as the DUT produces each beat rising edge.
// Hand-written sequences cover reset, abort, enable freeze, continuous wrap
// and ignored requests. Cycle t counts clock edges after the start request;
// outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_hrv_beat_gen;

    localparam int TICK_DIV = 4;
    localparam int PULSE_W  = 2;

    typedef struct packed {
        logic [7:0]  base_rr;
        logic [3:0]  delta;
        logic [7:0]  n_beats;
        logic [11:0] e0;
        logic [11:0] e1;
        logic [11:0] e2;
        logic [11:0] e3;
        logic [11:0] e4;
        logic [11:0] done_at;
    } vec_t;

    typedef struct {
        int t;
        int cnt;
    } exp_edge_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       start;
    logic       abort;
    logic [7:0] base_rr;
    logic [3:0] delta;
    logic [7:0] n_beats;
    logic       beat;
    logic [7:0] beat_cnt;
    logic       busy;
    logic       done;

    int         n_vectors = 0;
    int         n_miscompares = 0;
    int         t = 0;
    exp_edge_t  sb[$];
    vec_t       vecs[8];

    hrv_beat_gen #(
        .TICK_DIV (TICK_DIV),
        .PULSE_W  (PULSE_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .start    (start),
        .abort    (abort),
        .base_rr  (base_rr),
        .delta    (delta),
        .n_beats  (n_beats),
        .beat     (beat),
        .beat_cnt (beat_cnt),
        .busy     (busy),
        .done     (done)
    );

    // 100 MHz bench clock.
    always #5 clk = ~clk;

    // Hard stop in case some sequence never returns.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: every check counts as one vector.
    task automatic checkOutput(input string name, input int actual, input int expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s at t=%0d: got %0d, expected %0d", name, t, actual, expected);
        end
    endtask

    // Advance one clock: one-shot requests drop just after the rising edge,
    // outputs are then sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        t++;
        @(negedge clk);
    endtask

    // Drive a start request for a table entry and queue its expected edges.
    task automatic applyStimulus(input vec_t v);
        int        ev[5];
        exp_edge_t e;
        ev[0] = int'(v.e0);
        ev[1] = int'(v.e1);
        ev[2] = int'(v.e2);
        ev[3] = int'(v.e3);
        ev[4] = int'(v.e4);
        base_rr = v.base_rr;
        delta   = v.delta;
        n_beats = v.n_beats;
        start   = 1'b1;
        t       = 0;
        for (int i = 0; i < 5 && i < int'(v.n_beats); i++) begin
            e.t   = ev[i];
            e.cnt = i + 1;
            sb.push_back(e);
        end
    endtask

    // Run one finite burst. After acceptance the config inputs are scrambled
    // to prove they were latched; poke_at optionally fires an extra start
    // (with a different config) that must be ignored.
    task automatic runVector(input vec_t v, input int poke_at);
        logic      prev_beat;
        int        done_seen;
        int        limit;
        exp_edge_t e;
        prev_beat = 1'b0;
        done_seen = 0;
        applyStimulus(v);
        limit = int'(v.done_at) + 8;
        while (t < limit) begin
            step();
            if (t == 1) begin
                base_rr = 8'($urandom);
                delta   = 4'($urandom);
                n_beats = 8'($urandom);
            end
            if (beat && !prev_beat) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_edge", t, -1);
                end else begin
                    e = sb.pop_front();
                    checkOutput("edge_time", t, e.t);
                    checkOutput("edge_cnt", int'(beat_cnt), e.cnt);
                    checkOutput("edge_busy", int'(busy), 1);
                end
            end
            if (done) begin
                done_seen++;
                checkOutput("done_time", t, int'(v.done_at));
                checkOutput("done_busy", int'(busy), 0);
                checkOutput("done_beat", int'(beat), 0);
            end
            prev_beat = beat;
            if (t == poke_at) begin
                start   = 1'b1;
                base_rr = 8'd1;
                delta   = 4'd0;
                n_beats = 8'd1;
            end
        end
        checkOutput("done_count", done_seen, 1);
        checkOutput("edges_left", sb.size(), 0);
        checkOutput("final_busy", int'(busy), 0);
        checkOutput("final_cnt", int'(beat_cnt), int'(v.n_beats));
        sb.delete();
    endtask

    // Main test sequence.
    initial begin
        int   k;
        int   last_edge;
        int   done_seen;
        logic prev;

        // Expected edge cycles and done cycle follow I_k = sat(base + off).
        vecs[0] = '{8'd5,   4'd2,  8'd5, 12'd1, 12'd29,   12'd49,   12'd61, 12'd81, 12'd83};
        vecs[1] = '{8'd1,   4'd3,  8'd4, 12'd1, 12'd17,   12'd21,   12'd25, 12'd0,  12'd27};
        vecs[2] = '{8'd254, 4'd5,  8'd2, 12'd1, 12'd1021, 12'd0,    12'd0,  12'd0,  12'd1023};
        vecs[3] = '{8'd0,   4'd0,  8'd3, 12'd1, 12'd5,    12'd9,    12'd0,  12'd0,  12'd11};
        vecs[4] = '{8'd10,  4'd15, 8'd3, 12'd1, 12'd101,  12'd141,  12'd0,  12'd0,  12'd143};
        vecs[5] = '{8'd200, 4'd15, 8'd3, 12'd1, 12'd861,  12'd1661, 12'd0,  12'd0,  12'd1663};
        vecs[6] = '{8'd6,   4'd3,  8'd5, 12'd1, 12'd37,   12'd61,   12'd73, 12'd97, 12'd99};
        vecs[7] = '{8'd1,   4'd0,  8'd1, 12'd1, 12'd0,    12'd0,    12'd0,  12'd0,  12'd3};

        rst_n   = 1'b0;
        ena     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        base_rr = 8'd0;
        delta   = 4'd0;
        n_beats = 8'd0;

        // Reset values, during and just after reset.
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_beat", int'(beat), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_cnt", int'(beat_cnt), 0);
        rst_n = 1'b1;
        step();
        checkOutput("post_rst_busy", int'(busy), 0);
        checkOutput("post_rst_beat", int'(beat), 0);

        // start together with abort in IDLE is ignored.
        base_rr = 8'd5;
        n_beats = 8'd3;
        start   = 1'b1;
        abort   = 1'b1;
        step();
        checkOutput("sa_busy", int'(busy), 0);
        checkOutput("sa_beat", int'(beat), 0);
        checkOutput("sa_cnt", int'(beat_cnt), 0);
        step();
        checkOutput("sa_busy2", int'(busy), 0);
        checkOutput("sa_beat2", int'(beat), 0);

        // Table-driven finite bursts.
        for (int i = 0; i < 8; i++) begin
            $display("[TB] vector %0d: base_rr=%0d delta=%0d n_beats=%0d", i,
                     vecs[i].base_rr, vecs[i].delta, vecs[i].n_beats);
            runVector(vecs[i], -1);
        end

        // Start while busy (in WAIT, in PULSE) and in FIN must be ignored.
        runVector(vecs[0], 10);
        runVector(vecs[0], 29);
        runVector(vecs[0], 83);

        // Abort during the second beat's PULSE, then restart two cycles later.
        base_rr = 8'd5;
        delta   = 4'd2;
        n_beats = 8'd5;
        start   = 1'b1;
        t       = 0;
        done_seen = 0;
        while (t < 29) begin
            step();
            if (done) done_seen++;
        end
        checkOutput("ab_in_pulse", int'(beat), 1);
        checkOutput("ab_cnt_before", int'(beat_cnt), 2);
        abort = 1'b1;
        step();
        checkOutput("ab_beat", int'(beat), 0);
        checkOutput("ab_busy", int'(busy), 0);
        checkOutput("ab_done", int'(done), 0);
        checkOutput("ab_cnt", int'(beat_cnt), 2);
        step();
        if (done) done_seen++;
        checkOutput("ab_busy2", int'(busy), 0);
        checkOutput("ab_no_done", done_seen, 0);
        start = 1'b1;
        step();
        checkOutput("ab_restart_beat", int'(beat), 1);
        checkOutput("ab_restart_busy", int'(busy), 1);
        checkOutput("ab_restart_cnt", int'(beat_cnt), 1);
        abort = 1'b1;
        step();
        checkOutput("ab_clear_busy", int'(busy), 0);

        // Enable freeze for 7 cycles during WAIT of the first interval.
        base_rr = 8'd3;
        delta   = 4'd0;
        n_beats = 8'd2;
        start   = 1'b1;
        t       = 0;
        while (t < 5) step();
        checkOutput("frz_in_wait", int'(beat), 0);
        ena = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            checkOutput("frz_beat", int'(beat), 0);
            checkOutput("frz_cnt", int'(beat_cnt), 1);
            checkOutput("frz_busy", int'(busy), 1);
        end
        ena = 1'b1;
        while (!beat && t < 40) step();
        checkOutput("frz_edge_time", t, 20);
        checkOutput("frz_edge_cnt", int'(beat_cnt), 2);
        while (!done && t < 40) step();
        checkOutput("frz_done_time", t, 22);
        checkOutput("frz_done_busy", int'(busy), 0);
        step();

        // Continuous mode: edges every 4 cycles, beat_cnt wraps at beat 256.
        base_rr   = 8'd1;
        delta     = 4'd0;
        n_beats   = 8'd0;
        start     = 1'b1;
        t         = 0;
        k         = 0;
        last_edge = 0;
        done_seen = 0;
        prev      = 1'b0;
        while (k < 258 && t < 1100) begin
            step();
            if (done) done_seen++;
            if (beat && !prev) begin
                k++;
                checkOutput("cont_spacing", t - last_edge, (k == 1) ? 1 : 4);
                checkOutput("cont_cnt", int'(beat_cnt), k % 256);
                last_edge = t;
            end
            prev = beat;
        end
        checkOutput("cont_edges", k, 258);
        checkOutput("cont_busy", int'(busy), 1);
        checkOutput("cont_no_done", done_seen, 0);
        abort = 1'b1;
        step();
        checkOutput("cont_abort_busy", int'(busy), 0);
        checkOutput("cont_abort_beat", int'(beat), 0);

        // Asynchronous reset in the middle of a PULSE.
        base_rr = 8'd5;
        delta   = 4'd2;
        n_beats = 8'd5;
        start   = 1'b1;
        t       = 0;
        step();
        checkOutput("ar_beat_before", int'(beat), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("ar_beat", int'(beat), 0);
        checkOutput("ar_busy", int'(busy), 0);
        checkOutput("ar_done", int'(done), 0);
        checkOutput("ar_cnt", int'(beat_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checkOutput("ar_idle_busy", int'(busy), 0);
        checkOutput("ar_idle_beat", int'(beat), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
